cnt_compare_capture: RTL and testbench

Compare/capture stage downstream of the 16-bit counter: consumes its counter value and overflow flag and produces a compare-match event, a PWM waveform and a capture register. The compare value is double-buffered and reloads only on the period boundary, so software writes never glitch the PWM. Three sticky event flags combine into one maskable interrupt.

---
 rtl/cnt_compare_capture_if.sv | 30 +++
 rtl/cnt_compare_capture.sv | 117 +++++++++++
 tb/tb_cnt_compare_capture.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_compare_capture_if.sv
// Bus bundle between the counter stage / software side and cnt_compare_capture.
// The slave modport is the compare/capture block; master is whoever drives it.
interface cnt_compare_capture_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] i_cnt;
   logic             i_ovf_flg;
   logic             i_cmp_wr;
   logic [WIDTH-1:0] i_cmp_data;
   logic             i_cap_trig;
   logic [2:0]       i_flg_clr;
   logic [2:0]       i_irq_en;
   logic [WIDTH-1:0] o_cmp_active;
   logic             o_cmp_match;
   logic             o_pwm;
   logic [WIDTH-1:0] o_cap_data;
   logic             o_cap_vld;
   logic [2:0]       o_flg;
   logic             o_irq;

   modport slave (
      input  i_cnt, i_ovf_flg, i_cmp_wr, i_cmp_data, i_cap_trig, i_flg_clr, i_irq_en,
      output o_cmp_active, o_cmp_match, o_pwm, o_cap_data, o_cap_vld, o_flg, o_irq
   );

   modport master (
      output i_cnt, i_ovf_flg, i_cmp_wr, i_cmp_data, i_cap_trig, i_flg_clr, i_irq_en,
      input  o_cmp_active, o_cmp_match, o_pwm, o_cap_data, o_cap_vld, o_flg, o_irq
   );
endinterface

// File: rtl/cnt_compare_capture.sv
// Compare/capture stage: double-buffered compare, PWM, capture register, sticky flags, IRQ.
// Capture path is present only when CNT_CMP_CAPTURE_EN is defined.
module cnt_compare_capture #(
   parameter int WIDTH = 16
) (
   input  logic                  i_sysclk,
   input  logic                  i_sysrst,
   cnt_compare_capture_if.slave  bus
);

   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] active_q;
   logic             pending_q;
   logic             ovf_q;
   logic             eq_q;
   logic             match_q;
   logic             pwm_q;
   logic [2:0]       flg_q;
   logic             irq_q;

   logic             pe;
   logic             eq;
   logic             me;
   logic             reload;
   logic [WIDTH-1:0] active_post;
   logic [1:0]       cap_set;
   logic [2:0]       flg_n;

`ifdef CNT_CMP_CAPTURE_EN
   localparam logic [2:0] FLG_MASK = 3'b111;
`else
   localparam logic [2:0] FLG_MASK = 3'b001;
`endif

   // Match is judged against the active value as it stands before this cycle's reload.
   assign pe          = bus.i_ovf_flg & ~ovf_q;
   assign eq          = (bus.i_cnt == active_q);
   assign me          = eq & ~eq_q;
   assign reload      = pe & pending_q;
   assign active_post = reload ? shadow_q : active_q;
   assign flg_n       = ({cap_set, me} | (flg_q & ~bus.i_flg_clr)) & FLG_MASK;

   // NOTE: all state uses non-blocking assignment so every register samples pre-edge values;
   // that is what makes a same-cycle write and reload pick up the old shadow.
   always_ff @(posedge i_sysclk) begin
      if (!i_sysrst) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         ovf_q     <= 1'b0;
         eq_q      <= 1'b0;
         match_q   <= 1'b0;
         pwm_q     <= 1'b0;
         flg_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         ovf_q   <= bus.i_ovf_flg;
         eq_q    <= eq;
         match_q <= me;
         flg_q   <= flg_n;
         irq_q   <= |(flg_q & bus.i_irq_en);

         if (bus.i_cmp_wr) begin
            shadow_q  <= bus.i_cmp_data;
            pending_q <= 1'b1;
         end else if (reload) begin
            pending_q <= 1'b0;
         end

         if (reload) active_q <= shadow_q;

         // Period start wins over a coincident match, giving 100% duty at compare = all-ones.
         if (pe)      pwm_q <= (active_post != '0);
         else if (me) pwm_q <= 1'b0;
      end
   end

`ifdef CNT_CMP_CAPTURE_EN
   logic             cap_trig_q;
   logic             cap_vld_q;
   logic [WIDTH-1:0] cap_data_q;
   logic             cap_edge;

   assign cap_edge = bus.i_cap_trig & ~cap_trig_q;
   // Overrun is raised when a capture lands while the previous one is still unacknowledged.
   assign cap_set  = {cap_edge & flg_q[1], cap_edge};

   always_ff @(posedge i_sysclk) begin
      if (!i_sysrst) begin
         cap_trig_q <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_data_q <= '0;
      end else begin
         cap_trig_q <= bus.i_cap_trig;
         cap_vld_q  <= cap_edge;
         if (cap_edge) cap_data_q <= bus.i_cnt;
      end
   end

   assign bus.o_cap_data = cap_data_q;
   assign bus.o_cap_vld  = cap_vld_q;
`else
   logic unused_cap_trig;

   assign unused_cap_trig = bus.i_cap_trig;
   assign cap_set         = 2'b00;
   assign bus.o_cap_data  = '0;
   assign bus.o_cap_vld   = 1'b0;
`endif

   assign bus.o_cmp_active = active_q;
   assign bus.o_cmp_match  = match_q;
   assign bus.o_pwm        = pwm_q;
   assign bus.o_flg        = flg_q;
   assign bus.o_irq        = irq_q;

endmodule

// File: tb/tb_cnt_compare_capture.sv
// Directed bench for cnt_compare_capture; expectations adapt to CNT_CMP_CAPTURE_EN.
module tb_cnt_compare_capture;

   localparam int WIDTH = 16;
`ifdef CNT_CMP_CAPTURE_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   logic i_sysclk = 1'b0;
   logic i_sysrst = 1'b0;
   int   n_vec    = 0;
   int   n_miscmp = 0;

   cnt_compare_capture_if #(.WIDTH(WIDTH)) bus ();

   cnt_compare_capture #(.WIDTH(WIDTH)) dut (
      .i_sysclk (i_sysclk),
      .i_sysrst (i_sysrst),
      .bus      (bus.slave)
   );

   always #5 i_sysclk = ~i_sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_sysclk);
      #1;
   endtask

   // Drive a counter value (overflow flag follows all-ones) and advance one clock.
   task automatic cnt_step(input logic [WIDTH-1:0] v);
      bus.i_cnt     = v;
      bus.i_ovf_flg = (v == '1);
      step();
   endtask

   task automatic wr_step(input logic [WIDTH-1:0] cnt_v, input logic [WIDTH-1:0] data);
      bus.i_cmp_wr   = 1'b1;
      bus.i_cmp_data = data;
      cnt_step(cnt_v);
      bus.i_cmp_wr   = 1'b0;
   endtask

   initial begin
      bus.i_cnt      = 16'h0100;
      bus.i_ovf_flg  = 1'b0;
      bus.i_cmp_wr   = 1'b0;
      bus.i_cmp_data = '0;
      bus.i_cap_trig = 1'b0;
      bus.i_flg_clr  = '0;
      bus.i_irq_en   = '0;

      // Reset state
      step();
      step();
      check("rst_active",  bus.o_cmp_active, 0);
      check("rst_match",   bus.o_cmp_match,  0);
      check("rst_pwm",     bus.o_pwm,        0);
      check("rst_capdata", bus.o_cap_data,   0);
      check("rst_capvld",  bus.o_cap_vld,    0);
      check("rst_flg",     bus.o_flg,        0);
      check("rst_irq",     bus.o_irq,        0);

      // Reload timing: a mid-period write waits for the next period event
      i_sysrst = 1'b1;
      cnt_step(16'h0100);
      wr_step(16'h0101, 16'h0010);
      check("rl_hold0", bus.o_cmp_active, 0);
      cnt_step(16'h0102);
      check("rl_hold1", bus.o_cmp_active, 0);
      cnt_step(16'hFFFF);
      check("rl_load",  bus.o_cmp_active, 16'h0010);
      check("rl_pwm_up", bus.o_pwm, 1);
      cnt_step(16'h0000);
      cnt_step(16'h000F);
      check("rl_pwm_hi", bus.o_pwm, 1);
      cnt_step(16'h0010);
      check("me_pulse", bus.o_cmp_match, 1);
      check("me_pwm_dn", bus.o_pwm, 0);
      check("me_flg", bus.o_flg, 3'b001);
      cnt_step(16'h0011);
      check("me_one_cycle", bus.o_cmp_match, 0);

      // PWM duty with compare 0x8000
      wr_step(16'h0012, 16'h8000);
      cnt_step(16'hFFFF);
      check("d8_active", bus.o_cmp_active, 16'h8000);
      check("d8_rise", bus.o_pwm, 1);
      cnt_step(16'h0000);
      cnt_step(16'h7FFF);
      check("d8_hi", bus.o_pwm, 1);
      cnt_step(16'h8000);
      check("d8_fall", bus.o_pwm, 0);
      check("d8_match", bus.o_cmp_match, 1);

      // Compare all-ones: period start beats the coincident match
      wr_step(16'h8001, 16'hFFFF);
      cnt_step(16'hFFFF);
      check("dff_active", bus.o_cmp_active, 16'hFFFF);
      check("dff_pwm0", bus.o_pwm, 1);
      cnt_step(16'h0000);
      cnt_step(16'h8000);
      check("dff_pwm1", bus.o_pwm, 1);
      cnt_step(16'hFFFF);
      check("dff_pwm2", bus.o_pwm, 1);
      check("dff_match", bus.o_cmp_match, 1);

      // Stalled counter: one period event, one reload
      cnt_step(16'h0000);
      wr_step(16'h0001, 16'h0020);
      cnt_step(16'hFFFF);
      check("stall_load", bus.o_cmp_active, 16'h0020);
      for (int i = 1; i < 10; i++) begin
         bus.i_cmp_wr   = (i == 3);
         bus.i_cmp_data = 16'h0030;
         cnt_step(16'hFFFF);
      end
      bus.i_cmp_wr = 1'b0;
      check("stall_once", bus.o_cmp_active, 16'h0020);
      check("stall_pwm", bus.o_pwm, 1);
      cnt_step(16'h0000);
      cnt_step(16'hFFFF);
      check("stall_next", bus.o_cmp_active, 16'h0030);

      // Compare zero: output stays low
      cnt_step(16'h0000);
      wr_step(16'h0001, 16'h0000);
      cnt_step(16'h0030);
      check("d0_fall", bus.o_pwm, 0);
      cnt_step(16'hFFFF);
      check("d0_active", bus.o_cmp_active, 0);
      check("d0_pe_low", bus.o_pwm, 0);
      cnt_step(16'h0000);
      check("d0_match", bus.o_cmp_match, 1);
      check("d0_low", bus.o_pwm, 0);
      cnt_step(16'h8000);
      check("d0_low2", bus.o_pwm, 0);

      // Interrupt mask and latency
      bus.i_flg_clr = 3'b111;
      cnt_step(16'h8001);
      bus.i_flg_clr = 3'b000;
      check("clr_all", bus.o_flg, 0);
      bus.i_irq_en = 3'b001;
      cnt_step(16'h0000);
      check("irq_flg", bus.o_flg, 3'b001);
      check("irq_lat1", bus.o_irq, 0);
      cnt_step(16'h0001);
      check("irq_lat2", bus.o_irq, 1);
      bus.i_flg_clr = 3'b001;
      cnt_step(16'h0002);
      bus.i_flg_clr = 3'b000;
      check("irq_clr_flg", bus.o_flg, 0);
      check("irq_clr_lat1", bus.o_irq, 1);
      cnt_step(16'h0003);
      check("irq_clr_lat2", bus.o_irq, 0);

      // Capture and overrun
      bus.i_cap_trig = 1'b1;
      cnt_step(16'h1234);
      check("cap1_data", bus.o_cap_data, CAP_EN ? 16'h1234 : 16'h0000);
      check("cap1_vld", bus.o_cap_vld, CAP_EN);
      check("cap1_flg", bus.o_flg, CAP_EN ? 3'b010 : 3'b000);
      cnt_step(16'h1235);
      check("cap_level", bus.o_cap_vld, 0);
      bus.i_cap_trig = 1'b0;
      cnt_step(16'h1236);
      bus.i_cap_trig = 1'b1;
      cnt_step(16'h2000);
      check("cap2_data", bus.o_cap_data, CAP_EN ? 16'h2000 : 16'h0000);
      check("cap2_vld", bus.o_cap_vld, CAP_EN);
      check("cap2_ovr", bus.o_flg, CAP_EN ? 3'b110 : 3'b000);
      bus.i_cap_trig = 1'b0;
      cnt_step(16'h2001);
      check("cap_masked_irq", bus.o_irq, 0);
      bus.i_cap_trig = 1'b1;
      bus.i_flg_clr  = 3'b010;
      cnt_step(16'h2002);
      bus.i_cap_trig = 1'b0;
      bus.i_flg_clr  = 3'b000;
      check("cap_set_wins", bus.o_flg, CAP_EN ? 3'b110 : 3'b000);

      // Counting down through the compare value still matches
      cnt_step(16'h0002);
      cnt_step(16'h0001);
      cnt_step(16'h0000);
      check("down_match", bus.o_cmp_match, 1);

      // Reset mid-period with PWM high and a write pending
      wr_step(16'h0005, 16'h0040);
      cnt_step(16'hFFFF);
      check("pre_rst_pwm", bus.o_pwm, 1);
      wr_step(16'h0001, 16'h0050);
      i_sysrst = 1'b0;
      cnt_step(16'h0002);
      check("mrst_active",  bus.o_cmp_active, 0);
      check("mrst_pwm",     bus.o_pwm,        0);
      check("mrst_match",   bus.o_cmp_match,  0);
      check("mrst_capdata", bus.o_cap_data,   0);
      check("mrst_capvld",  bus.o_cap_vld,    0);
      check("mrst_flg",     bus.o_flg,        0);
      check("mrst_irq",     bus.o_irq,        0);
      i_sysrst = 1'b1;
      cnt_step(16'h0003);
      cnt_step(16'hFFFF);
      check("post_rst_active", bus.o_cmp_active, 0);
      check("post_rst_pwm", bus.o_pwm, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
